// File: rtl/hemps_debug_log_buffer_if.sv
// ---------------------------------------------------------------------------
// hemps_debug_log_buffer_if
//
// Bundles the HeMPS debug-channel producer signals and the framed log stream
// consumed by the host log path.
//
// Modports:
//   slave  - the log buffer itself: takes the debug words and log_ready, and
//            drives busy_debug, the log stream, overflow and level.
//   master - the environment: drives the debug words and log_ready, and
//            observes everything else.
//
// Signals:
//   write_enable_debug  producer strobe, one word per asserted cycle
//   data_out_debug      debug word, sampled when write_enable_debug=1
//   busy_debug          backpressure to the producer
//   log_valid           output word available
//   log_data            output word (FIFO head)
//   log_last            current output word ends its message
//   log_ready           consumer accepts the word on log_valid & log_ready
//   overflow            sticky flag, a word was dropped
//   level               current FIFO occupancy
// ---------------------------------------------------------------------------
interface hemps_debug_log_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic                  write_enable_debug;
  logic [DATA_WIDTH-1:0] data_out_debug;
  logic                  busy_debug;
  logic                  log_valid;
  logic [DATA_WIDTH-1:0] log_data;
  logic                  log_last;
  logic                  log_ready;
  logic                  overflow;
  logic [LEVEL_W-1:0]    level;

  modport slave (
    input  write_enable_debug,
    input  data_out_debug,
    input  log_ready,
    output busy_debug,
    output log_valid,
    output log_data,
    output log_last,
    output overflow,
    output level
  );

  modport master (
    output write_enable_debug,
    output data_out_debug,
    output log_ready,
    input  busy_debug,
    input  log_valid,
    input  log_data,
    input  log_last,
    input  overflow,
    input  level
  );
endinterface

// File: rtl/hemps_debug_log_buffer.sv
// ---------------------------------------------------------------------------
// hemps_debug_log_buffer
//
// Captures words from the HeMPS debug output channel into a first-word-
// fall-through FIFO. It pushes back on the producer through busy_debug and
// drains the buffered words over a valid/ready stream toward the host log
// path. A framing FSM watches the words as they leave. Each message is a
// header whose low 16 bits give the payload length N, followed by N payload
// words. The FSM flags the final word of every message on log_last.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    hemps_debug_log_buffer_if.slave (debug channel + log stream)
//
// Parameters:
//   DATA_WIDTH      width of a debug word (>= 16, header length in [15:0])
//   DEPTH           FIFO entries, power of two, >= 4
//   BUSY_THRESHOLD  busy_debug asserts when free entries <= this (1..DEPTH-1)
// ---------------------------------------------------------------------------
module hemps_debug_log_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int BUSY_THRESHOLD = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  hemps_debug_log_buffer_if.slave   bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  localparam logic [LEVEL_W-1:0] DEPTH_L     = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] THRESHOLD_L = LEVEL_W'(BUSY_THRESHOLD);

  typedef enum logic {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } frame_state_t;

  // -------------------------------------------------------------------------
  // Storage and state
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic [LEVEL_W-1:0] level_next;
  logic               busy_reg;
  logic               busy_next;
  logic               overflow_reg;
  frame_state_t       state_reg;
  logic [15:0]        count_reg;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic                  fifo_valid;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] head_word;
  logic [15:0]           head_len;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  last_word;
  logic [LEVEL_W-1:0]    free_next;

  // Occupancy alone decides empty/full, so the pointers may freely alias.
  assign fifo_valid = (level_reg != '0);
  assign fifo_full  = (level_reg == DEPTH_L);

  // First-word-fall-through: the head entry is read combinationally.
  assign head_word  = mem[rd_ptr_reg];
  assign head_len   = head_word[15:0];

  assign pop  = fifo_valid & bus.log_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push = bus.write_enable_debug & (~fifo_full | pop);
  assign drop = bus.write_enable_debug & ~push;

  always_comb begin
    level_next = level_reg;
    unique case ({push, pop})
      2'b10:   level_next = level_reg + LEVEL_W'(1);
      2'b01:   level_next = level_reg - LEVEL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Busy is computed from the occupancy the FIFO will have next cycle. The
  // producer therefore sees it at the same time as the new level, and it
  // still has BUSY_THRESHOLD free slots to absorb words already in flight.
  assign free_next = DEPTH_L - level_next;
  assign busy_next = (free_next <= THRESHOLD_L);

  // -------------------------------------------------------------------------
  // Storage write port. The array holds no reset because emptiness is
  // tracked by level_reg, so stale contents are never presented.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.data_out_debug;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, occupancy, backpressure and overflow
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg <= level_next;
      busy_reg  <= busy_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Framing FSM, which advances only when a word leaves. count_reg holds the
  // number of payload words still owed, including the current head. A
  // 16-bit count with N up to 0xFFFF never wraps because it is only loaded
  // with N > 0 and leaves PAYLOAD at 1.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= HEADER;
      count_reg <= '0;
    end else if (pop) begin
      unique case (state_reg)
        HEADER: begin
          if (head_len != 16'd0) begin
            count_reg <= head_len;
            state_reg <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          count_reg <= count_reg - 16'd1;
          if (count_reg == 16'd1) begin
            state_reg <= HEADER;
          end
        end
        default: begin
          state_reg <= HEADER;
        end
      endcase
    end
  end

  always_comb begin
    last_word = 1'b0;
    unique case (state_reg)
      HEADER:  last_word = (head_len == 16'd0);
      PAYLOAD: last_word = (count_reg == 16'd1);
      default: last_word = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Data and last are forced to zero whenever nothing is valid.
  // Because level_reg clears asynchronously, the whole stream side goes
  // quiet the moment reset asserts, without waiting for a clock edge.
  // -------------------------------------------------------------------------
  assign bus.log_valid  = fifo_valid;
  assign bus.log_data   = fifo_valid ? head_word : '0;
  assign bus.log_last   = fifo_valid & last_word;
  assign bus.busy_debug = busy_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.level      = level_reg;

endmodule

// File: tb/tb_hemps_debug_log_buffer.sv
// ---------------------------------------------------------------------------
// tb_hemps_debug_log_buffer
//
// Drives hemps_debug_log_buffer with directed sequences and randomized
// traffic. A queue-based reference model tracks the expected buffered
// words, message position, overflow and occupancy. Each cycle the DUT
// outputs are compared against the model half a clock after the active
// edge. Hand-computed literal values pin the key scenarios: frame order,
// last flags, busy onset, drop count and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_hemps_debug_log_buffer;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int THR = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  hemps_debug_log_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

  hemps_debug_log_buffer #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEP),
    .BUSY_THRESHOLD(THR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered words, payload words still owed by the
  // current message (0 means the head is a header), sticky overflow.
  logic [DW-1:0] mq[$];
  int            m_rem;
  bit            m_ovf;

  // Words observed leaving the DUT: {log_last, log_data}.
  logic [DW:0]   dut_out[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit            e_valid;
    logic [DW-1:0] e_data;
    bit            e_last;
    e_valid = (mq.size() != 0);
    e_data  = e_valid ? mq[0] : '0;
    if (!e_valid)
      e_last = 1'b0;
    else if (m_rem == 0)
      e_last = (e_data[15:0] == 16'd0);
    else
      e_last = (m_rem == 1);
    chk("log_valid", bus.log_valid, e_valid);
    chk("log_data",  bus.log_data,  e_data);
    chk("log_last",  bus.log_last,  e_last);
    chk("level",     bus.level,     mq.size());
    chk("busy",      bus.busy_debug, (DEP - mq.size()) <= THR);
    chk("overflow",  bus.overflow,  m_ovf);
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model,
  // then compare on the falling edge.
  task automatic cycle(input bit we, input logic [DW-1:0] d, input bit rdy);
    bit            pop;
    bit            ok;
    logic [DW-1:0] head;
    bus.write_enable_debug = we;
    bus.data_out_debug     = d;
    bus.log_ready          = rdy;
    pop  = (mq.size() != 0) && rdy;
    ok   = we && ((mq.size() < DEP) || pop);
    head = (mq.size() != 0) ? mq[0] : '0;
    if (bus.log_valid && rdy) dut_out.push_back({bus.log_last, bus.log_data});
    @(posedge clock);
    if (pop) begin
      if (m_rem == 0) m_rem = int'(head[15:0]);
      else            m_rem = m_rem - 1;
      void'(mq.pop_front());
    end
    if (we) begin
      if (ok) mq.push_back(d);
      else    m_ovf = 1'b1;
    end
    @(negedge clock);
    compare();
  endtask

  // Asserts reset between edges and checks that outputs clear without a
  // clock edge, then releases it after a falling edge.
  task automatic do_reset();
    bus.write_enable_debug = 1'b0;
    bus.data_out_debug     = '0;
    bus.log_ready          = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_valid", bus.log_valid,  0);
    chk("rst_async_data",  bus.log_data,   0);
    chk("rst_async_last",  bus.log_last,   0);
    chk("rst_async_level", bus.level,      0);
    chk("rst_async_busy",  bus.busy_debug, 0);
    chk("rst_async_ovf",   bus.overflow,   0);
    mq.delete();
    m_rem = 0;
    m_ovf = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    compare();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            gen_rem;
    bit            we;
    bit            rdy;

    bus.write_enable_debug = 1'b0;
    bus.data_out_debug     = '0;
    bus.log_ready          = 1'b0;
    m_rem = 0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    compare();

    // Idle after reset release.
    repeat (10) cycle(1'b0, '0, 1'b0);
    chk("idle_level", bus.level, 0);
    chk("idle_valid", bus.log_valid, 0);

    // Header N=2 plus two payload words.
    dut_out.delete();
    cycle(1'b1, 32'h0000_0002, 1'b1);
    chk("first_valid_latency", bus.log_valid, 1);
    cycle(1'b1, 32'hAAAA_0001, 1'b1);
    cycle(1'b1, 32'hBBBB_0002, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("msg2_count", dut_out.size(), 3);
    if (dut_out.size() == 3) begin
      chk("msg2_w0", dut_out[0], {1'b0, 32'h0000_0002});
      chk("msg2_w1", dut_out[1], {1'b0, 32'hAAAA_0001});
      chk("msg2_w2", dut_out[2], {1'b1, 32'hBBBB_0002});
    end

    // N=0 header is a message on its own; the next word is a header again.
    dut_out.delete();
    cycle(1'b1, 32'h1234_0000, 1'b1);
    cycle(1'b1, 32'h0000_0001, 1'b1);
    cycle(1'b1, 32'h5555_0001, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("msg0_count", dut_out.size(), 3);
    if (dut_out.size() == 3) begin
      chk("msg0_w0", dut_out[0], {1'b1, 32'h1234_0000});
      chk("msg0_w1", dut_out[1], {1'b0, 32'h0000_0001});
      chk("msg0_w2", dut_out[2], {1'b1, 32'h5555_0001});
    end

    // Fill with log_ready low: busy onset, drops and sticky overflow.
    for (int i = 0; i < 20; i++) begin
      d = {16'hC000 + 16'(i), 16'h0000};
      cycle(1'b1, d, 1'b0);
      if (i == 12) begin
        chk("fill13_level", bus.level, 13);
        chk("fill13_busy",  bus.busy_debug, 0);
      end
      if (i == 13) begin
        chk("fill14_level", bus.level, 14);
        chk("fill14_busy",  bus.busy_debug, 1);
      end
    end
    chk("fill20_level", bus.level, 16);
    chk("fill20_ovf",   bus.overflow, 1);
    dut_out.delete();
    repeat (20) cycle(1'b0, '0, 1'b1);
    chk("drain_count", dut_out.size(), 16);
    if (dut_out.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk("drain_word", dut_out[i], {1'b1, 16'hC000 + 16'(i), 16'h0000});
    end
    chk("drain_ovf_sticky", bus.overflow, 1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, {16'hD000 + 16'(i), 16'h0000}, 1'b0);
    chk("full_level", bus.level, 16);
    chk("full_busy",  bus.busy_debug, 1);
    dut_out.delete();
    cycle(1'b1, 32'hF00D_0000, 1'b1);
    chk("pushpop_level", bus.level, 16);
    chk("pushpop_ovf",   bus.overflow, 0);
    repeat (17) cycle(1'b0, '0, 1'b1);
    chk("pushpop_count", dut_out.size(), 17);
    if (dut_out.size() == 17) begin
      chk("pushpop_first", dut_out[0],  {1'b1, 32'hD000_0000});
      chk("pushpop_tail",  dut_out[16], {1'b1, 32'hF00D_0000});
    end

    // Reset in the middle of a 5-word payload, then a fresh message.
    cycle(1'b1, 32'h0000_0005, 1'b1);
    cycle(1'b1, 32'h1111_0001, 1'b1);
    cycle(1'b1, 32'h1111_0002, 1'b1);
    cycle(1'b1, 32'h1111_0003, 1'b0);
    do_reset();
    dut_out.delete();
    cycle(1'b1, 32'h0000_0001, 1'b1);
    cycle(1'b1, 32'hDEAD_0001, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("post_rst_count", dut_out.size(), 2);
    if (dut_out.size() == 2) begin
      chk("post_rst_w0", dut_out[0], {1'b0, 32'h0000_0001});
      chk("post_rst_w1", dut_out[1], {1'b1, 32'hDEAD_0001});
    end

    // Randomized traffic: short framed messages, varying consumer pressure.
    gen_rem = 0;
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 3) != 0);
      if (i < 1000)      rdy = $urandom_range(0, 1) == 1;
      else if (i < 2000) rdy = $urandom_range(0, 4) == 0;
      else               rdy = $urandom_range(0, 4) != 0;
      if (gen_rem == 0) begin
        d = {16'($urandom), 16'($urandom_range(0, 3))};
        gen_rem = int'(d[15:0]);
      end else begin
        d = $urandom;
        gen_rem = gen_rem - 1;
      end
      if (!we) d = $urandom;
      if (!we && gen_rem > 0 && d[15:0] != 0) gen_rem = gen_rem;
      cycle(we, d, rdy);
    end
    repeat (40) cycle(1'b0, '0, 1'b1);
    chk("final_level", bus.level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
